// File: rtl/cmd_spi_slave_if.sv
// cmd_spi_slave_if
// Host SPI link pins (mode 0) shared between the host model and the
// command decoder.
//   sck  : host SPI clock, asynchronous to clk
//   mosi : host-to-slave serial data
//   csn  : frame select, active low
//   miso : slave-to-host read data
// Modports:
//   master : host side (drives sck/mosi/csn, receives miso)
//   slave  : decoder side (receives sck/mosi/csn, drives miso)
interface cmd_spi_slave_if;
  logic sck;
  logic mosi;
  logic csn;
  logic miso;

  modport master (output sck, output mosi, output csn, input miso);
  modport slave  (input sck, input mosi, input csn, output miso);
endinterface

// File: rtl/cmd_spi_slave.sv
// cmd_spi_slave
// Oversampled SPI slave command decoder. Receives 24-bit host frames
// (W, addr[6:0], data[15:0], MSB first) and drives the AGC DAC and I/Q ADC
// control registers and their one-cycle load strobes. Everything runs on
// clk; the SPI pins are synchronized internally.
// Ports:
//   clk, arstn                  : system clock, async active-low reset
//   spi (slave modport)         : sck/mosi/csn in, miso out
//   fifo_wrcnt                  : status input, readable at 0x04
//   adc_i_enable, adc_q_enable  : ADC enables (CTRL 0x00)
//   agc_data, agc_load          : AGC DAC code and write strobe (0x01)
//   adc_i_ctrlword, adc_i_ldctrl: I ADC control word and strobe (0x02)
//   adc_q_ctrlword, adc_q_ldctrl: Q ADC control word and strobe (0x03)
//   frame_err                   : sticky frame-error flag, cleared by a
//                                 STATUS read
module cmd_spi_slave #(
  parameter int          SYNC_STAGES    = 2,
  parameter logic [15:0] ID_VALUE       = 16'hB5C0,
  parameter logic [11:0] AGC_RESET      = 12'h555,
  parameter logic [9:0]  ADC_CTRL_RESET = 10'b0000100100
) (
  input  logic                  clk,
  input  logic                  arstn,
  cmd_spi_slave_if.slave        spi,
  input  logic [10:0]           fifo_wrcnt,
  output logic                  adc_i_enable,
  output logic                  adc_q_enable,
  output logic [11:0]           agc_data,
  output logic                  agc_load,
  output logic [9:0]            adc_i_ctrlword,
  output logic                  adc_i_ldctrl,
  output logic [9:0]            adc_q_ctrlword,
  output logic                  adc_q_ldctrl,
  output logic                  frame_err
);

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, csn_sync;
  logic        sck_d, csn_d;
  logic        sck_s, mosi_s, csn_s;
  logic        sck_rise, sck_fall, csn_rise, csn_fall;
  logic        sample_bit, shift_out, frame_end;
  logic [4:0]  bit_cnt;
  logic [23:0] shreg;
  logic [15:0] tx_reg, rd_data;
  logic [6:0]  hdr_addr, cmd_addr;
  logic [15:0] cmd_data;
  logic        read_req, commit_req, err_req;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign csn_rise = csn_s & ~csn_d;
  assign csn_fall = ~csn_s & csn_d;

  // After 8 bits the header sits in the low byte; after a full frame the
  // command occupies all 24 bits.
  assign hdr_addr = shreg[6:0];
  assign cmd_addr = shreg[22:16];
  assign cmd_data = shreg[15:0];

  // Pin synchronizers plus one extra flop each on sck/csn for edge
  // detection. The csn chain resets low so that a csn held low across reset
  // never looks like a frame start; only a real high-to-low transition
  // after reset opens a frame.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      csn_sync  <= '0;
      sck_d     <= 1'b0;
      csn_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi.csn};
      sck_d     <= sck_s;
      csn_d     <= csn_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= ST_IDLE;
    else        state <= state_next;
  end

  // A frame is open only between a seen csn fall and the following csn
  // rise; sck activity outside an open frame is ignored.
  always_comb begin
    state_next = state;
    sample_bit = 1'b0;
    shift_out  = 1'b0;
    frame_end  = 1'b0;
    if (csn_fall) begin
      state_next = ST_FRAME;
    end else if (state == ST_FRAME) begin
      if (csn_rise) begin
        state_next = ST_IDLE;
        frame_end  = 1'b1;
      end else begin
        sample_bit = sck_rise;
        shift_out  = sck_fall;
      end
    end
  end

  // Receive shift register and saturating bit counter.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      bit_cnt <= 5'd0;
      shreg   <= 24'd0;
    end else if (csn_fall) begin
      bit_cnt <= 5'd0;
      shreg   <= 24'd0;
    end else if (sample_bit) begin
      shreg <= {shreg[22:0], mosi_s};
      if (bit_cnt != 5'd25) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // Requests registered one cycle after the triggering event. A read is
  // requested when the 8th bit lands and the W bit (already in shreg[6])
  // is 0.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      read_req   <= 1'b0;
      commit_req <= 1'b0;
      err_req    <= 1'b0;
    end else begin
      read_req   <= sample_bit && (bit_cnt == 5'd7) && !shreg[6];
      commit_req <= frame_end && (bit_cnt == 5'd24) && shreg[23];
      err_req    <= frame_end && (bit_cnt != 5'd24) && (bit_cnt != 5'd0);
    end
  end

  // Read-back mux; unused bits and unmapped addresses read as zero.
  always_comb begin
    rd_data = 16'd0;
    case (hdr_addr)
      7'h00:   rd_data = {14'd0, adc_q_enable, adc_i_enable};
      7'h01:   rd_data = {4'd0, agc_data};
      7'h02:   rd_data = {6'd0, adc_i_ctrlword};
      7'h03:   rd_data = {6'd0, adc_q_ctrlword};
      7'h04:   rd_data = {frame_err, 4'd0, fifo_wrcnt};
      7'h7F:   rd_data = ID_VALUE;
      default: rd_data = 16'd0;
    endcase
  end

  // Transmit path: tx_reg is cleared at frame start, so miso carries zeros
  // through the header until the read value is latched; each synchronized
  // sck fall then moves the next bit onto miso.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tx_reg   <= 16'd0;
      spi.miso <= 1'b0;
    end else begin
      if (csn_fall)       tx_reg <= 16'd0;
      else if (read_req)  tx_reg <= rd_data;
      else if (shift_out) tx_reg <= {tx_reg[14:0], 1'b0};

      if (state != ST_FRAME || frame_end) spi.miso <= 1'b0;
      else if (shift_out)                 spi.miso <= tx_reg[15];
    end
  end

  // Control registers, load strobes and the sticky frame error. The error
  // set takes priority over a STATUS-read clear landing in the same cycle.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      adc_i_enable   <= 1'b0;
      adc_q_enable   <= 1'b0;
      agc_data       <= AGC_RESET;
      adc_i_ctrlword <= ADC_CTRL_RESET;
      adc_q_ctrlword <= ADC_CTRL_RESET;
      agc_load       <= 1'b0;
      adc_i_ldctrl   <= 1'b0;
      adc_q_ldctrl   <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      agc_load     <= 1'b0;
      adc_i_ldctrl <= 1'b0;
      adc_q_ldctrl <= 1'b0;
      if (commit_req) begin
        case (cmd_addr)
          7'h00: begin
            adc_i_enable <= cmd_data[0];
            adc_q_enable <= cmd_data[1];
          end
          7'h01: begin
            agc_data <= cmd_data[11:0];
            agc_load <= 1'b1;
          end
          7'h02: begin
            adc_i_ctrlword <= cmd_data[9:0];
            adc_i_ldctrl   <= 1'b1;
          end
          7'h03: begin
            adc_q_ctrlword <= cmd_data[9:0];
            adc_q_ldctrl   <= 1'b1;
          end
          default: ;
        endcase
      end
      if (err_req)                               frame_err <= 1'b1;
      else if (read_req && (hdr_addr == 7'h04))  frame_err <= 1'b0;
    end
  end

endmodule
